event_pulse_scheduler: RTL

Converts N synchronous level inputs (buttons, status lines) into single-cycle rising-edge events, with optional hold-to-repeat. Queues one pending event per channel and serializes them round-robin onto a single valid/ready event stream. Sits between the input synchronizer/debounce stage and the command decoder that consumes one event at a time.

---
 rtl/event_sched_pkg.sv | 17 +
 rtl/event_channel.sv | 65 ++++++
 rtl/event_pulse_scheduler.sv | 92 +++++++++
 3 files changed

// File: rtl/event_sched_pkg.sv
// Shared types and constants for the event pulse scheduler: output-stage state
// encoding, default repeat timing and the channel-index width helper.
package event_sched_pkg;

   typedef enum logic {
      STATE_EMPTY = 1'b0,
      STATE_FULL  = 1'b1
   } schedState;

   localparam int DEF_REPEAT_DELAY  = 1000;
   localparam int DEF_REPEAT_PERIOD = 250;

   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/event_channel.sv
// One input channel: rising-edge detect, hold-to-repeat counter and the
// single-entry pending slot with its sticky overflow flag.
module event_channel
   import event_sched_pkg::*;
#(
   parameter int CNT_W         = 16,
   parameter int REPEAT_EN     = 1,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic sigIn,
   input  logic loadSel,
   input  logic clrDropped,
   output logic pending,
   output logic rep,
   output logic dropped
);

   localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

   logic             lag;
   logic [CNT_W-1:0] holdCnt;
   logic             rise;
   logic             repeatHit;
   logic             evt;
   logic             drop;

   assign rise      = sigIn & ~lag;
   assign repeatHit = (REPEAT_EN != 0) && sigIn && !rise && (holdCnt == CNT_TOP);
   assign evt       = rise | repeatHit;
   // A slot being handed to the output this cycle can take the new event.
   assign drop      = evt & pending & ~loadSel;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         lag     <= 1'b0;
         holdCnt <= '0;
         pending <= 1'b0;
         rep     <= 1'b0;
         dropped <= 1'b0;
      end else begin
         lag <= sigIn;

         if ((REPEAT_EN == 0) || !sigIn || rise) holdCnt <= '0;
         else if (holdCnt == CNT_TOP)             holdCnt <= CNT_RELOAD;
         else                                     holdCnt <= holdCnt + 1'b1;

         if (evt && !drop) begin
            pending <= 1'b1;
            rep     <= repeatHit;
         end else if (loadSel) begin
            pending <= 1'b0;
         end

         if (drop)            dropped <= 1'b1;
         else if (clrDropped) dropped <= 1'b0;
      end
   end

endmodule

// File: rtl/event_pulse_scheduler.sv
// Turns N level inputs into edge/repeat events and serializes the pending ones
// round-robin onto a single valid/ready stream.
module event_pulse_scheduler
   import event_sched_pkg::*;
#(
   parameter int N_CH          = 4,
   parameter int IDX_W         = idxWidth(N_CH),
   parameter int CNT_W         = 16,
   parameter int REPEAT_EN     = 1,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  sig_in,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [IDX_W-1:0] evt_idx,
   output logic             evt_repeat,
   output logic [N_CH-1:0]  pending,
   output logic [N_CH-1:0]  dropped,
   input  logic [N_CH-1:0]  clr_dropped
);

   schedState        state, stateNext;
   logic [IDX_W-1:0] ptr, selIdx, cand;
   logic [N_CH-1:0]  chRep, loadSel;
   logic             anyPending, load;

   for (genvar i = 0; i < N_CH; i++) begin : gChan
      event_channel #(
         .CNT_W        (CNT_W),
         .REPEAT_EN    (REPEAT_EN),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) uChan (
         .clk       (clk),
         .rst       (rst),
         .sigIn     (sig_in[i]),
         .loadSel   (loadSel[i]),
         .clrDropped(clr_dropped[i]),
         .pending   (pending[i]),
         .rep       (chRep[i]),
         .dropped   (dropped[i])
      );
   end

   // Search starts just after the last served channel, so it is served last.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      selIdx     = '0;
      cand       = '0;
      anyPending = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         cand = IDX_W'((int'(ptr) + k) % N_CH);
         if (!anyPending && pending[cand]) begin
            anyPending = 1'b1;
            selIdx     = cand;
         end
      end
   end

   assign load      = (state == STATE_EMPTY) || evt_ready;
   assign evt_valid = (state == STATE_FULL);

   always_comb begin
      stateNext = state;
      loadSel   = '0;
      if (load) begin
         stateNext = anyPending ? STATE_FULL : STATE_EMPTY;
         if (anyPending) loadSel[selIdx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= STATE_EMPTY;
      else      state <= stateNext;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         evt_idx    <= '0;
         evt_repeat <= 1'b0;
         ptr        <= IDX_W'(N_CH - 1);
      end else if (load && anyPending) begin
         evt_idx    <= selIdx;
         evt_repeat <= chRep[selIdx];
         ptr        <= selIdx;
      end
   end

endmodule
